// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
package tdm_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int MISS_LIMIT = 2;

   function automatic int slot_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Mod-N_CH slot counter: clear, load-to-1 (frame start), increment with wrap, or hold.
module tdm_slot_counter #(
   parameter int N_CH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    load,
   input  logic                    inc,
   output logic [$clog2(N_CH)-1:0] cnt
);
   localparam int CW = $clog2(N_CH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= CW'(1);
      end else if (inc) begin
         cnt <= (cnt == CW'(N_CH - 1)) ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: aligns to frame_sync, stages slots, publishes whole frames atomically.
//   state  | meaning
//   HUNT   | not aligned; beats discarded until one carries frame_sync
//   LOCKED | aligned; beats stored by slot, frame published after slot N_CH-1
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W-1:0]      din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [N_CH*W-1:0] ch_data,
   output logic [N_CH-1:0]   ch_valid,
   output logic              frame_valid,
   output logic              locked,
   output logic              sync_err
);
   localparam int CW = $clog2(N_CH);

   state_t            state, state_nx;
   logic [1:0]        miss, miss_nx;
   logic [CW-1:0]     cnt;
   logic              cnt_clr, cnt_load, cnt_inc;
   logic              store, publish, err_nx;
   logic [CW-1:0]     store_idx;
   logic [N_CH-1:0]   cv_nx;
   logic [W-1:0]      staging [N_CH];
   logic [N_CH*W-1:0] pub_word;

   tdm_slot_counter #(.N_CH(N_CH)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .load (cnt_load),
      .inc  (cnt_inc),
      .cnt  (cnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HUNT;
         miss  <= '0;
      end else begin
         state <= state_nx;
         miss  <= miss_nx;
      end
   end

   always_comb begin
      state_nx = state;
      miss_nx  = miss;
      cnt_clr  = 1'b0;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      store    = 1'b0;
      publish  = 1'b0;
      err_nx   = 1'b0;
      if (din_valid) begin
         case (state)
            HUNT: begin
               if (frame_sync) begin
                  state_nx = LOCKED;
                  cnt_load = 1'b1;
                  store    = 1'b1;
                  miss_nx  = '0;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  cnt_load = 1'b1;
                  store    = 1'b1;
                  if (cnt == '0) miss_nx = '0;
                  else           err_nx  = 1'b1;
               end else if (cnt == '0 && miss == 2'(MISS_LIMIT - 1)) begin
                  // second consecutive missed sync: give up alignment, drop this beat
                  state_nx = HUNT;
                  cnt_clr  = 1'b1;
                  miss_nx  = '0;
               end else begin
                  store   = 1'b1;
                  cnt_inc = 1'b1;
                  if (cnt == '0)              miss_nx = miss + 2'd1;
                  if (cnt == CW'(N_CH - 1))   publish = 1'b1;
               end
            end
            default: state_nx = HUNT;
         endcase
      end
   end

   assign store_idx = frame_sync ? '0 : cnt;

   always_comb begin
      cv_nx    = '0;
      pub_word = '0;
      for (int k = 0; k < N_CH; k++) begin
         cv_nx[k] = store && (store_idx == CW'(k));
         // the last slot is published straight from din, same cycle it arrives
         pub_word[slot_lsb(k, W) +: W] = (k == N_CH - 1) ? din : staging[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) staging[k] <= '0;
      end else if (store) begin
         for (int k = 0; k < N_CH; k++)
            if (store_idx == CW'(k)) staging[k] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_data     <= '0;
         ch_valid    <= '0;
         frame_valid <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         ch_valid    <= cv_nx;
         frame_valid <= publish;
         locked      <= (state_nx == LOCKED);
         sync_err    <= err_nx;
         if (publish) ch_data <= pub_word;
      end
   end

endmodule
